montred_final_sub: RTL



---
 rtl/montred_pkg.sv | 27 ++
 rtl/montred_q_gen.sv | 58 +++++
 rtl/montred_final_sub.sv | 126 ++++++++++++
 3 files changed

// File: rtl/montred_pkg.sv
// Shared constants, configuration record and q construction for the Montgomery final-subtract stage.
package montred_pkg;

  localparam int K           = 54;
  localparam int M           = 17;
  localparam int W           = 24;
  localparam int IN_BITS     = K + 2;
  localparam int Q_BASE_BITS = 46;
  localparam int K_MAX_SEL   = 8;

  typedef struct packed {
    logic [M-1:0] q_m;
    logic [3:0]   current_k;
  } montred_cfg_t;

  // q = 2^(current_k+46) - q_m*2^W + 1, K+1 bits wide so the 2^54 term fits
  function automatic logic [K:0] montred_q(input logic [M-1:0] q_m, input logic [3:0] current_k);
    logic [K:0] one;
    logic [K:0] pow2;
    logic [K:0] qm_sh;
    one   = {{K{1'b0}}, 1'b1};
    pow2  = one << (Q_BASE_BITS + int'(current_k));
    qm_sh = {{(K + 1 - M - W){1'b0}}, q_m, {W{1'b0}}};
    return pow2 - qm_sh + one;
  endfunction

endpackage

// File: rtl/montred_q_gen.sv
// Holds the active modulus configuration and the registered q derived from it.
// A load is taken only when the pipeline is idle; q settles one cycle later (cfg_pending).
module montred_q_gen
  import montred_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [M-1:0] q_m,
  input  logic [3:0]   current_k,
  input  logic         pipe_busy,
  output logic         cfg_pending,
  output logic         cfg_busy,
  output logic [K:0]   q
);

  localparam logic [K:0] Q_RST = montred_q('0, '0);

  montred_cfg_t cfg_q, cfg_d;
  logic         pending_q, pending_d;
  logic [K:0]   q_q, q_d;
  logic         load_ok;
  logic [3:0]   k_clamped;

  assign cfg_busy  = pipe_busy | pending_q;
  assign load_ok   = cfg_load & ~cfg_busy;
  assign k_clamped = (current_k > 4'(K_MAX_SEL)) ? 4'(K_MAX_SEL) : current_k;

  always_comb begin
    cfg_d     = cfg_q;
    pending_d = 1'b0;
    q_d       = q_q;
    if (load_ok) begin
      cfg_d.q_m       = q_m;
      cfg_d.current_k = k_clamped;
      pending_d       = 1'b1;
    end
    if (pending_q) begin
      q_d = montred_q(cfg_q.q_m, cfg_q.current_k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= '0;
      pending_q <= 1'b0;
      q_q       <= Q_RST;
    end else begin
      cfg_q     <= cfg_d;
      pending_q <= pending_d;
      q_q       <= q_d;
    end
  end

  assign cfg_pending = pending_q;
  assign q           = q_q;

endmodule

// File: rtl/montred_final_sub.sv
// Folds the last reduction stage's [-q, 2q) result into [0, q); 2-cycle latency, 1 word/cycle.
// Valid/ready back-pressure without bubbles; MONTRED_FINAL_RANGE_CHECK_EN adds a sticky range_err.
module montred_final_sub
  import montred_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [M-1:0]       q_m,
  input  logic [3:0]         current_k,
  output logic               cfg_busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_BITS-1:0] in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [K-1:0]       out
`ifdef MONTRED_FINAL_RANGE_CHECK_EN
  ,
  output logic               range_err
`endif
);

  logic [K:0] q;
  logic       cfg_pending;
  logic       v1_q, v2_q;
  logic       adv1, adv2, acc;

  montred_q_gen u_q_gen (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .q_m         (q_m),
    .current_k   (current_k),
    .pipe_busy   (v1_q | v2_q),
    .cfg_pending (cfg_pending),
    .cfg_busy    (cfg_busy),
    .q           (q)
  );

  assign adv2     = ~v2_q | out_ready;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1 & ~cfg_pending;
  assign acc      = in_valid & in_ready;

  logic signed [IN_BITS:0] in_x, q_x;
  logic                    neg, ge;
  logic [K-1:0]            sub_lo, add_lo;

  assign in_x = signed'({in[IN_BITS-1], in});
  assign q_x  = signed'({2'b00, q});
  assign neg  = in[IN_BITS-1];
  assign ge   = in_x >= q_x;
  // Only the low K bits of in+-q survive truncation, so K-bit modular sums suffice
  assign sub_lo = in[K-1:0] - q[K-1:0];
  assign add_lo = in[K-1:0] + q[K-1:0];

  logic [K-1:0] s1_in_q, s1_sub_q, s1_add_q;
  logic         s1_neg_q, s1_ge_q;
  logic [K-1:0] out_q, out_d;

  always_comb begin
    out_d = s1_in_q;
    if (s1_neg_q) begin
      out_d = s1_add_q;
    end else if (s1_ge_q) begin
      out_d = s1_sub_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      s1_in_q  <= '0;
      s1_sub_q <= '0;
      s1_add_q <= '0;
      s1_neg_q <= 1'b0;
      s1_ge_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      if (adv1) begin
        v1_q <= acc;
      end
      if (acc) begin
        s1_in_q  <= in[K-1:0];
        s1_sub_q <= sub_lo;
        s1_add_q <= add_lo;
        s1_neg_q <= neg;
        s1_ge_q  <= ge;
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          out_q <= out_d;
        end
      end
    end
  end

  assign out_valid = v2_q;
  assign out       = out_q;

`ifdef MONTRED_FINAL_RANGE_CHECK_EN
  logic rerr_in, s1_rerr_q, range_err_q;

  assign rerr_in = (in_x < -q_x) || (in_x >= (q_x <<< 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rerr_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      if (acc) begin
        s1_rerr_q <= rerr_in;
      end
      if (adv2 && v1_q && s1_rerr_q) begin
        range_err_q <= 1'b1;
      end
    end
  end

  assign range_err = range_err_q;
`endif

endmodule
